// File: rtl/preif_if_skid_reg_pkg.sv
// Shared definitions for the pre-IF -> IF pipeline register.
// Holds the default PC width, the default reset PC, the default lane count,
// a helper that derives the PC bundle width, and the occupancy encoding.
// The occupancy encoding is derived from the MAIN and SKID valid bits.
package preif_if_skid_reg_pkg;

  localparam int unsigned PC_WIDTH     = 32;
  localparam logic [31:0] RESET_PC_VAL = 32'h1c00_0000;
  localparam int unsigned DEF_LANES    = 2;

  // Width of the packed PC bundle: lane i sits at [i*pc_w +: pc_w].
  function automatic int unsigned preif_to_if_bus_width(input int unsigned lanes,
                                                        input int unsigned pc_w);
    return lanes * pc_w;
  endfunction

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd3
  } occ_e;

  // A SKID-only pattern cannot arise in normal operation. It is treated as
  // FULL so that it drains into MAIN instead of sticking.
  function automatic occ_e occ_of(input logic main_vld, input logic skid_vld);
    if (skid_vld) return OCC_FULL;
    if (main_vld) return OCC_ONE;
    return OCC_EMPTY;
  endfunction

endpackage

// File: rtl/preif_if_skid_reg_pipe_skid_slot.sv
// pipe_skid_slot: one pipeline slot, made of a valid bit plus a data register.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   ld              load d into the data register and set valid
//   clr             clear valid; it wins over ld. Data is left untouched.
//   d               data to load
//   vld, q          slot valid and slot data
// The data register is reset only when DATA_RST=1. It is used that way for
// the slot whose contents are visible on the outputs.
module pipe_skid_slot
  import preif_if_skid_reg_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter bit                DATA_RST = 1'b0,
  parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic              vld,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
    end else if (clr) begin
      vld <= 1'b0;
    end else if (ld) begin
      vld <= 1'b1;
    end
  end

  generate
    if (DATA_RST) begin : g_data_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= RST_VAL;
        end else if (ld) begin
          q <= d;
        end
      end
    end else begin : g_data_nrst
      always_ff @(posedge clk) begin
        if (ld) begin
          q <= d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/preif_if_skid_reg.sv
// preif_if_skid_reg: pre-IF -> IF pipeline register with a one-entry skid
// buffer. preif_allowin_o is taken straight from a flop, so IF's allowin
// never reaches pre-IF combinationally.
// Ports:
//   clk                 clock
//   rst_n               asynchronous reset, active-high (1 = reset)
//   preif_to_if_valid_i upstream bundle valid
//   preif_allowin_o     registered upstream allowin
//   preif_to_ibus       LANES PCs, lane i at [i*PC_W +: PC_W]
//   preif_lane_mask_i   per-lane valid bits
//   if_allowin_i        IF can take a bundle this cycle
//   if_valid_o          bundle to IF valid
//   to_if_obus          PC bundle to IF
//   if_lane_mask_o      lane mask to IF
//   excep_flush_i       flush; squashes MAIN, SKID and any simultaneous input
module preif_if_skid_reg
  import preif_if_skid_reg_pkg::*;
#(
  parameter int unsigned     LANES    = DEF_LANES,
  parameter int unsigned     PC_W     = PC_WIDTH,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_VAL)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  preif_to_if_valid_i,
  output logic                  preif_allowin_o,
  input  logic [LANES*PC_W-1:0] preif_to_ibus,
  input  logic [LANES-1:0]      preif_lane_mask_i,
  input  logic                  if_allowin_i,
  output logic                  if_valid_o,
  output logic [LANES*PC_W-1:0] to_if_obus,
  output logic [LANES-1:0]      if_lane_mask_o,
  input  logic                  excep_flush_i
);

  localparam int unsigned BUS_W  = preif_to_if_bus_width(LANES, PC_W);
  localparam int unsigned SLOT_W = BUS_W + LANES;

  // Lane i resets to RESET_PC - 4*(LANES-1-i), so the top lane holds RESET_PC.
  function automatic logic [BUS_W-1:0] reset_pcs();
    logic [BUS_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      r[i*PC_W +: PC_W] = RESET_PC - PC_W'(4 * (int'(LANES) - 1 - i));
    end
    return r;
  endfunction

  localparam logic [SLOT_W-1:0] MAIN_RST = {{LANES{1'b1}}, reset_pcs()};

  logic              main_vld, skid_vld;
  logic [SLOT_W-1:0] main_q, skid_q, main_d, in_bundle;
  logic              main_ld, main_clr, main_from_skid;
  logic              skid_ld, skid_clr, skid_nxt;
  logic              allowin_q;
  logic              acc, xfer;
  occ_e              occ;

  assign in_bundle = {preif_lane_mask_i, preif_to_ibus};
  assign acc       = preif_to_if_valid_i & allowin_q;
  assign xfer      = main_vld & if_allowin_i;
  assign occ       = occ_of(main_vld, skid_vld);

  always_comb begin
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (excep_flush_i) begin
      // Only the valid bits are cleared; the input is dropped.
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (occ)
        OCC_EMPTY: main_ld = acc;
        OCC_ONE: begin
          if (acc) begin
            if (xfer) main_ld = 1'b1;
            else      skid_ld = 1'b1;
          end else if (xfer) begin
            main_clr = 1'b1;
          end
        end
        OCC_FULL: begin
          // allowin is low in FULL, so no accept competes with the drain.
          if (xfer || !main_vld) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign main_d   = main_from_skid ? skid_q : in_bundle;
  assign skid_nxt = skid_clr ? 1'b0 : (skid_ld ? 1'b1 : skid_vld);

  // MAIN slot: drives the IF-facing outputs
  pipe_skid_slot #(
    .DATA_W  (SLOT_W),
    .DATA_RST(1'b1),
    .RST_VAL (MAIN_RST)
  ) u_main (
    .clk(clk),
    .rst(rst_n),
    .ld (main_ld),
    .clr(main_clr),
    .d  (main_d),
    .vld(main_vld),
    .q  (main_q)
  );

  // SKID slot: overflow entry, drained into MAIN before any newer bundle
  pipe_skid_slot #(
    .DATA_W  (SLOT_W),
    .DATA_RST(1'b0),
    .RST_VAL ('0)
  ) u_skid (
    .clk(clk),
    .rst(rst_n),
    .ld (skid_ld),
    .clr(skid_clr),
    .d  (in_bundle),
    .vld(skid_vld),
    .q  (skid_q)
  );

  // allowin is precomputed from the next SKID valid, so it is a flop output.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      allowin_q <= 1'b1;
    end else begin
      allowin_q <= ~skid_nxt;
    end
  end

  assign preif_allowin_o               = allowin_q;
  assign if_valid_o                    = main_vld;
  assign {if_lane_mask_o, to_if_obus}  = main_q;

endmodule

// File: doc/preif_if_skid_reg.md
# preif_if_skid_reg

Parametrised pre-IF → IF pipeline register for the multi-issue front end. It carries a bundle of LANES fetch PCs plus a per-lane valid mask from the PC-generation stage into IF. A one-entry skid buffer makes the upstream `preif_allowin_o` a pure register output, which cuts the combinational allowin chain from IF back into pre-IF. Exception flush squashes everything in flight.

## Interface
- `LANES`, default 2: PCs per fetch bundle (≥1).
- `PC_W`, default 32: PC width.
- `RESET_PC`, default 32'h1c00_0000: reset PC of the highest lane. Lane i resets to RESET_PC − 4·(LANES−1−i); with the defaults this gives lane0 = 1bff_fffc and lane1 = 1c00_0000.
- `clk` in 1: the only clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous reset, active-high (1 = reset asserted).
- `preif_to_if_valid_i` in 1: upstream bundle valid.
- `preif_allowin_o` out 1: registered; 1 means the block accepts a bundle this cycle.
- `preif_to_ibus` in LANES·PC_W: PC bundle; lane i occupies bits [i·PC_W +: PC_W].
- `preif_lane_mask_i` in LANES: per-lane valid bits.
- `if_allowin_i` in 1: IF stage can take a bundle this cycle.
- `if_valid_o` in/out: out 1, bundle presented to IF is valid.
- `to_if_obus` out LANES·PC_W: PC bundle to IF, same packing as the input.
- `if_lane_mask_o` out LANES: lane mask to IF.
- `excep_flush_i` in 1: exception/ertn flush.

## Operation
- Two slots:
  - MAIN, which drives the outputs.
  - SKID, which holds one overflow bundle.
- Occupancy states and their required outputs:
  - EMPTY (neither slot valid): if_valid_o=0, preif_allowin_o=1.
  - ONE (MAIN valid only): if_valid_o=1, preif_allowin_o=1.
  - FULL (both valid): if_valid_o=1, preif_allowin_o=0.
- Upstream accept: `acc = preif_to_if_valid_i & preif_allowin_o`.
- Downstream transfer: `xfer = if_valid_o & if_allowin_i`.
- Transitions when excep_flush_i=0:
  - EMPTY + acc → ONE. MAIN loads the input.
  - ONE + acc + xfer → ONE. MAIN loads the input.
  - ONE + acc + !xfer → FULL. SKID loads the input; MAIN holds.
  - ONE + !acc + xfer → EMPTY.
  - FULL + xfer → ONE. MAIN loads SKID. No accept is possible in FULL.
  - Any other combination: hold.
- Flush, when excep_flush_i=1:
  - Next state is EMPTY regardless of acc and xfer; an input presented in the same cycle is dropped.
  - PC and mask registers may keep stale data; only the valid bits are cleared.
- Data registers change only on a load. With no load, to_if_obus and if_lane_mask_o hold their previous values.
- An all-zero lane mask with valid=1 is still an ordinary bundle. It is accepted and forwarded unchanged; IF handles it.
- Ordering is strict FIFO. SKID is never bypassed by a newer input.

## Timing
- Reset values, forced asynchronously while rst_n=1:
  - if_valid_o=0
  - preif_allowin_o=1
  - state EMPTY
  - to_if_obus = per-lane reset PCs
  - if_lane_mask_o = all ones
- Latency: a bundle accepted in cycle t is visible on to_if_obus with if_valid_o=1 in cycle t+1, when the block was EMPTY or ONE with xfer.
- Throughput: one bundle per cycle while if_allowin_i stays at 1.
- preif_allowin_o drops in the cycle after entering FULL. It rises in the cycle after the FULL → ONE drain.
- Upstream must hold its data while valid & !allowin; the block samples only on acc.
- The block does not depend combinationally on upstream valid or data for any output.
- Reset release is synchronised externally. The first acc is legal in the first cycle with rst_n=0.

## Structure
- Shared header macros: the PC width, the reset PC, and the bundle width LANES·PC_W.
- Typical use is a generated bus, e.g. `PreifToIfBusWidth` built from LANES·PC_W. The default RESET_PC comes from the shared reset PC macro.
- One natural sub-module: `pipe_skid_slot`, a valid plus a data register with load/clear. Instantiate it twice (MAIN, SKID). The state encoding is derived from the two valid bits; no separate FSM register.

## Test plan
- Reset: assert rst_n mid-cycle → outputs take reset values immediately, with no clock edge needed. Defaults give to_if_obus={1c00_0000,1bff_fffc}, mask 2'b11, allowin=1, if_valid_o=0.
- Streaming: if_allowin_i=1, bundles {104,100}, {10c,108}, {114,110} on consecutive cycles → each appears one cycle later, back-to-back, with allowin constantly 1.
- Backpressure: hold MAIN={104,100} with if_allowin_i=0, then send {10c,108} → FULL and allowin=0 next cycle. Release if_allowin_i → {104,100} then {10c,108} in order, with allowin back to 1 after the drain.
- Flush in FULL with a simultaneous input valid → next cycle if_valid_o=0 and allowin=1. The flushed and the simultaneous bundles never appear.
- Hold stability: if_allowin_i=0 for 10 cycles in ONE → to_if_obus and mask are unchanged every cycle.
- Parameter sweep: LANES=4, PC_W=32 → lane reset PCs 1bff_fff4 … 1c00_0000. A mask of 4'b0101 is forwarded unchanged.
